// File: rtl/fbw_pkg.sv
// Shared constants and the framebuffer write-word payload for fb_write_coalescer.
package fbw_pkg;

    localparam int unsigned PIX_PER_WORD = 8;
    localparam int unsigned WORD_BYTES   = 16;
    localparam int unsigned PIX_W        = 16;
    localparam int unsigned DATA_W       = PIX_PER_WORD * PIX_W;
    localparam int unsigned MASK_W       = WORD_BYTES;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned LANE_W       = 3;
    localparam int unsigned GX_W         = COORD_W - LANE_W;
    localparam int unsigned FBW_ADDR_W   = 28;

    typedef struct packed {
        logic [FBW_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [MASK_W-1:0]     mask;
    } fb_word_t;

endpackage

// File: rtl/fbw_addr_calc.sv
// Registered framebuffer byte address of an 8-pixel group: FB_BASE + (y*FB_WIDTH + gx*8)*2.
module fbw_addr_calc
    import fbw_pkg::*;
#(
    parameter int unsigned       FB_WIDTH = 640,
    parameter int unsigned       ADDR_W   = FBW_ADDR_W,
    parameter logic [ADDR_W-1:0] FB_BASE  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COORD_W-1:0] y,
    input  logic [GX_W-1:0]    gx,
    output logic [ADDR_W-1:0]  addr_q
);

    localparam int unsigned CALC_W = (ADDR_W > 32) ? ADDR_W : 32;

    logic [CALC_W-1:0] pix_idx;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        pix_idx = CALC_W'(y) * CALC_W'(FB_WIDTH) + CALC_W'({gx, 3'b000});
        addr_d  = addr_q;
        if (load) begin
            addr_d = ADDR_W'(CALC_W'(FB_BASE) + (pix_idx << 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fb_write_coalescer.sv
// Merges span-ordered pixels into 128-bit masked framebuffer write words.
// Optional FBW_STATS_EN adds pixel/word/drop statistics counters.
module fb_write_coalescer
    import fbw_pkg::*;
#(
    parameter int unsigned       FB_WIDTH   = 640,
    parameter int unsigned       FB_HEIGHT  = 480,
    parameter int unsigned       ADDR_W     = FBW_ADDR_W,
    parameter logic [ADDR_W-1:0] FB_BASE    = '0,
    parameter int unsigned       IDLE_FLUSH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [PIX_W-1:0]   in_color,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush_req,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [DATA_W-1:0]  out_data,
    output logic [MASK_W-1:0]  out_mask,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef FBW_STATS_EN
    output logic [31:0]        stat_pixels,
    output logic [31:0]        stat_words,
    output logic [15:0]        stat_dropped,
`endif
    output logic               idle
);

    localparam int unsigned CNT_W = 8;

    logic               rst_done_q;
    logic               acc_valid_q, acc_valid_d;
    logic [COORD_W-1:0] acc_y_q, acc_y_d;
    logic [GX_W-1:0]    acc_gx_q, acc_gx_d;
    logic [DATA_W-1:0]  acc_data_q, acc_data_d;
    logic [MASK_W-1:0]  acc_mask_q, acc_mask_d;
    logic [ADDR_W-1:0]  acc_addr_q;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    fb_word_t           out_word_q, out_word_d;
    logic               out_valid_q, out_valid_d;
    logic               idle_q, idle_d;

    logic slot_free_c, accept_c, in_range_c, acc_in_c, same_grp_c;
    logic timeout_c, flush_c, start_c;

    // Input handshake depends only on the output slot, never on the pixel coordinates.
    always_comb begin
        slot_free_c = !out_valid_q || out_ready;
        in_ready    = rst_done_q && slot_free_c;
        accept_c    = in_valid && in_ready;
        in_range_c  = (32'(in_x) < FB_WIDTH) && (32'(in_y) < FB_HEIGHT);
        acc_in_c    = accept_c && in_range_c;
        same_grp_c  = (in_y == acc_y_q) && (in_x[COORD_W-1:LANE_W] == acc_gx_q);
        timeout_c   = (idle_cnt_q == CNT_W'(IDLE_FLUSH));
        flush_c     = slot_free_c && acc_valid_q &&
                      ((acc_mask_q == '0) || timeout_c || flush_pend_q ||
                       (acc_in_c && !same_grp_c));
        start_c     = acc_in_c && (flush_c || !acc_valid_q);
    end

    fbw_addr_calc #(
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W),
        .FB_BASE  (FB_BASE)
    ) u_addr_calc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_c),
        .y      (in_y),
        .gx     (in_x[COORD_W-1:LANE_W]),
        .addr_q (acc_addr_q)
    );

    // Accumulator: a flushed word frees it; an accepted pixel either starts it fresh or merges.
    always_comb begin
        acc_valid_d = acc_valid_q;
        acc_y_d     = acc_y_q;
        acc_gx_d    = acc_gx_q;
        acc_data_d  = acc_data_q;
        acc_mask_d  = acc_mask_q;
        if (flush_c) begin
            acc_valid_d = 1'b0;
        end
        if (start_c) begin
            acc_valid_d = 1'b1;
            acc_y_d     = in_y;
            acc_gx_d    = in_x[COORD_W-1:LANE_W];
            acc_data_d  = '0;
            acc_mask_d  = '1;
        end
        if (acc_in_c) begin
            for (int k = 0; k < int'(PIX_PER_WORD); k++) begin
                if (in_x[LANE_W-1:0] == LANE_W'(k)) begin
                    acc_data_d[k*PIX_W +: PIX_W] = in_color;
                    acc_mask_d[k*2 +: 2]         = 2'b00;
                end
            end
        end
    end

    // Idle timer and explicit flush request bookkeeping.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (acc_in_c || !acc_valid_q) begin
            idle_cnt_d = '0;
        end else if (!timeout_c) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end

        flush_pend_d = flush_pend_q;
        if (flush_c || !acc_valid_q) begin
            flush_pend_d = 1'b0;
        end
        if (flush_req) begin
            flush_pend_d = 1'b1;
        end
    end

    always_comb begin
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q && !out_ready;
        if (flush_c) begin
            out_word_d.addr = FBW_ADDR_W'(acc_addr_q);
            out_word_d.data = acc_data_q;
            out_word_d.mask = acc_mask_q;
            out_valid_d     = 1'b1;
        end
        idle_d = !acc_valid_d && !out_valid_d && !flush_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q   <= 1'b0;
            acc_valid_q  <= 1'b0;
            acc_y_q      <= '0;
            acc_gx_q     <= '0;
            acc_data_q   <= '0;
            acc_mask_q   <= '1;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            out_word_q   <= '{addr: '0, data: '0, mask: '1};
            out_valid_q  <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            rst_done_q   <= 1'b1;
            acc_valid_q  <= acc_valid_d;
            acc_y_q      <= acc_y_d;
            acc_gx_q     <= acc_gx_d;
            acc_data_q   <= acc_data_d;
            acc_mask_q   <= acc_mask_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            out_word_q   <= out_word_d;
            out_valid_q  <= out_valid_d;
            idle_q       <= idle_d;
        end
    end

    assign out_addr  = ADDR_W'(out_word_q.addr);
    assign out_data  = out_word_q.data;
    assign out_mask  = out_word_q.mask;
    assign out_valid = out_valid_q;
    assign idle      = idle_q;

`ifdef FBW_STATS_EN
    logic [31:0] stat_pixels_q, stat_pixels_d;
    logic [31:0] stat_words_q, stat_words_d;
    logic [15:0] stat_dropped_q, stat_dropped_d;

    always_comb begin
        stat_pixels_d  = stat_pixels_q + 32'(acc_in_c);
        stat_words_d   = stat_words_q + 32'(out_valid_q && out_ready);
        stat_dropped_d = stat_dropped_q + 16'(accept_c && !in_range_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pixels_q  <= '0;
            stat_words_q   <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_pixels_q  <= stat_pixels_d;
            stat_words_q   <= stat_words_d;
            stat_dropped_q <= stat_dropped_d;
        end
    end

    assign stat_pixels  = stat_pixels_q;
    assign stat_words   = stat_words_q;
    assign stat_dropped = stat_dropped_q;
`endif

endmodule
